// File: rtl/icache_responder.sv
// Direct-mapped instruction cache answering fetch requests; hits return in one cycle,
// misses stall the fetch stage while the whole line is refilled from main memory.
`default_nettype none

module icache_responder #(
    parameter int OFF_W = 2,
    parameter int IDX_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        flush,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        miss,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int WORDS = 1 << OFF_W;
    localparam int SETS  = 1 << IDX_W;
    localparam logic [OFF_W-1:0] CNT_ONE = {{(OFF_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REFILL  = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    logic [1:0]        state;
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [31:0]       data_mem [SETS*WORDS];

    logic [OFF_W-1:0]  cnt;
    logic [OFF_W-1:0]  ref_off;
    logic [IDX_W-1:0]  ref_idx;
    logic [TAG_W-1:0]  ref_tag;
    logic [31:0]       captured;
    logic              flush_pend;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic              ack_taken;
    logic              last_word;
    logic              unused_bits;

    assign req_off     = addr[2 +: OFF_W];
    assign req_idx     = addr[2+OFF_W +: IDX_W];
    assign req_tag     = addr[31 -: TAG_W];
    assign hit         = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign ack_taken   = (state == S_REFILL) && mem_req && mem_ack;
    assign last_word   = &cnt;
    assign unused_bits = ^addr[1:0];

    // Arrays carry no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (ack_taken) begin
            data_mem[{ref_idx, cnt}] <= mem_rdata;
            if (last_word) begin
                tag_mem[ref_idx] <= ref_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            valid       <= '0;
            cnt         <= '0;
            ref_off     <= '0;
            ref_idx     <= '0;
            ref_tag     <= '0;
            captured    <= '0;
            flush_pend  <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            miss        <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end
                    // A flush in the same cycle forces the access down the miss path.
                    if (rd_en && hit && !flush) begin
                        rdata       <= data_mem[{req_idx, req_off}];
                        rdata_valid <= 1'b1;
                        hit_count   <= hit_count + 16'd1;
                    end else if (rd_en) begin
                        state      <= S_REFILL;
                        miss       <= 1'b1;
                        miss_count <= miss_count + 16'd1;
                        cnt        <= '0;
                        ref_off    <= req_off;
                        ref_idx    <= req_idx;
                        ref_tag    <= req_tag;
                        mem_req    <= 1'b1;
                        mem_addr   <= {addr[31:2+OFF_W], {(OFF_W+2){1'b0}}};
                    end
                end
                S_REFILL: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (ack_taken) begin
                        if (cnt == ref_off) begin
                            captured <= mem_rdata;
                        end
                        cnt      <= cnt + CNT_ONE;
                        mem_addr <= mem_addr + 32'd4;
                        if (last_word) begin
                            valid[ref_idx] <= 1'b1;
                            mem_req        <= 1'b0;
                            state          <= S_RESPOND;
                        end
                    end
                end
                S_RESPOND: begin
                    rdata       <= captured;
                    rdata_valid <= 1'b1;
                    miss        <= 1'b0;
                    state       <= S_IDLE;
                    if (flush_pend || flush) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Responder side of the instruction-fetch read interface: answers the fetch stage's address/enable requests with instruction words.
- Holds a direct-mapped instruction cache between the fetch stage and a slow instruction main memory.
- On a hit, returns the word with 1-cycle latency, matching a synchronous instruction RAM.
- On a miss, asserts a stall, refills the whole line over a req/ack handshake, then returns the requested word.

Parameters:
- OFF_W, 2, log2 of words per line (default 4 words/line).
- IDX_W, 3, log2 of number of sets (default 8 sets).
- Derived: TAG_W = 30 - OFF_W - IDX_W (default 25).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  32  fetch byte address; addr[1:0] ignored. Must stay stable while miss=1.
- rd_en  in  1  fetch request this cycle; low = pipeline stalled.
- flush  in  1  invalidate all lines (fence.i).
- rdata  out  32  instruction word, registered.
- rdata_valid  out  1  rdata updated this cycle with a new fetch result.
- miss  out  1  refill in progress; pipeline must stall.
- mem_req  out  1  main-memory read request.
- mem_addr  out  32  word-aligned main-memory address.
- mem_ack  in  1  mem_rdata valid, request accepted.
- mem_rdata  in  32  main-memory read data.
- hit_count  out  16  wrapping hit counter.
- miss_count  out  16  wrapping miss counter.

Behaviour:
- Address split: offset = addr[2 +: OFF_W], index = addr[2+OFF_W +: IDX_W], tag = addr[31 -: TAG_W].
- Storage: data array, tag array, valid bit per set. Only valid bits are reset.
- Reset (async, rst_n=0):
  - state=IDLE; all valid=0.
  - rdata=0, rdata_valid=0, miss=0, mem_req=0, mem_addr=0, counters=0, pending flush cleared.
  - Takes effect immediately, including mid-refill; the partially refilled line stays invalid.
- States: IDLE, REFILL, RESPOND.
- IDLE:
  - rd_en=1 and hit (valid[index] and tag match): next edge rdata<=word, rdata_valid<=1, hit_count++.
  - rd_en=1 and miss: next edge state<=REFILL, miss<=1, miss_count++, word counter cnt<=0, line base latched from addr, mem_req<=1, mem_addr<=base. rdata_valid<=0 and rdata holds.
  - rd_en=0: rdata holds, rdata_valid<=0.
  - flush=1: all valid<=0 at the edge. If rd_en=1 in the same cycle, flush wins and the access is treated as a miss; no hit is counted.
- REFILL:
  - mem_req stays high and mem_addr stays stable until mem_ack. mem_ack while mem_req=0 is ignored.
  - On each mem_ack: data[index][cnt]<=mem_rdata; if cnt==offset, capture the word. Then cnt++ and mem_addr<=base+4*(cnt+1).
  - On the ack with cnt==2^OFF_W-1: tag and valid written, mem_req<=0, state<=RESPOND.
  - Minimum refill time is one cycle per word.
  - flush and rd_en are ignored in REFILL, except that flush is latched as pending.
- RESPOND (1 cycle):
  - rdata<=captured word, rdata_valid<=1, miss<=0, state<=IDLE.
  - If a flush is pending, all valid<=0 at this edge (the new line is invalidated too) and pending is cleared.
- Latency:
  - Hit: data at the edge after request.
  - Miss with mem_ack tied high: 1 + 2^OFF_W + 1 edges from request to rdata_valid.
- miss is a registered output, high from the edge after a missed request up to the RESPOND edge.
- Counters wrap 0xFFFF→0.

Test Plan:
- Cold miss:
  - Stimulus: reset, then rd_en=1, addr=0x0000_0104, mem_ack tied 1, mem_rdata=mem_addr^0xA5A5_0000.
  - Response: mem_addr sequence 0x100, 0x104, 0x108, 0x10C; miss high 5 cycles; rdata=0xA5A5_0104 with rdata_valid=1; miss_count=1.
- Hit after fill:
  - Stimulus: addr=0x10C next.
  - Response: rdata=0xA5A5_010C one cycle later; miss stays 0; hit_count=1.
- Conflict eviction:
  - Stimulus: addr=0x0000_0184 (same index, different tag), then 0x104.
  - Response: two refills, miss_count=3, correct data each time.
- Slow memory:
  - Stimulus: mem_ack high every 3rd cycle.
  - Response: mem_req and mem_addr stable between acks; 4 words are written; the requested word is returned once.
- Flush:
  - Stimulus: flush pulse in IDLE, then addr=0x10C.
  - Response: a miss and a refill occur.
  - Stimulus: flush during REFILL.
  - Response: the word is returned, then the next access to that line misses.
- Reset mid-refill:
  - Stimulus: drop rst_n after 2 acks.
  - Response: mem_req=0 and miss=0 immediately; after release, the same addr misses again.
